ps2_host_tx: RTL
================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, e.g. 0xED
//  (set LEDs), 0xF4 (enable) or 0xFF (reset), over the same PS2_CLK/PS2_DAT lines that the
//  keyboard press driver receives on. The top level wraps both lines open-drain:
//  PS2_x = x_oe ? 1'b0 : 1'bz.
//  While busy is high, the top level must gate the receiver's valid/makeBreak.
// PARAMETERS
//  INHIBIT_CYCLES  5000    clk cycles PS2_CLK is held low before the start bit (100 us at 50 MHz)
//  TIMEOUT_CYCLES  750000  max clk cycles between successive device falling edges (15 ms)
//  SYNC_STAGES     2       flip-flop synchronizer depth on ps2_clk_in / ps2_dat_in
// PORTS
//  clk         in   1  system clock (CLOCK_50)
//  resetn      in   1  synchronous, active-low reset
//  send        in   1  1-cycle request; accepted only when ready=1, ignored otherwise
//  cmd         in   8  byte to transmit; captured in the cycle send is accepted
//  ready       out  1  idle and able to accept send
//  busy        out  1  frame in progress (=~ready)
//  done        out  1  1-cycle pulse: frame ended and the device acked (data low at edge 11)
//  error       out  1  1-cycle pulse: frame ended with no ack, or the watchdog expired
//  ps2_clk_in  in   1  raw PS2_CLK line level
//  ps2_dat_in  in   1  raw PS2_DAT line level
//  ps2_clk_oe  out  1  1 = pull PS2_CLK low
//  ps2_dat_oe  out  1  1 = pull PS2_DAT low
// BEHAVIOUR
//  Reset values (resetn=0 on a rising clk edge): state=IDLE, ready=1, busy=0, done=0,
//   error=0, clk_oe=0, dat_oe=0, counters=0. A reset mid-frame releases both lines on the
//   next edge; the frame is dropped and neither done nor error pulses.
//  Line inputs are synchronized (SYNC_STAGES). fall = the synced clk line was 1 last cycle and is 0 now.
//  Load: send&&ready -> shreg <= {^~cmd, cmd}. The parity bit is odd parity.
//   The state goes to INHIBIT in the next cycle, so ready/busy change 1 cycle after send.
//  FSM states:
//   IDLE       clk_oe=0, dat_oe=0. Accepting send.
//   INHIBIT    clk_oe=1 for exactly INHIBIT_CYCLES cycles, then -> START.
//   START      clk_oe=1, dat_oe=1 (start bit) for 1 cycle, then -> RELEASE.
//   RELEASE    clk_oe=0, dat_oe=1. Zero the edge counter and the watchdog, then -> SHIFT.
//   SHIFT      On each fall, bitcnt++ and drive the next bit: dat_oe <= ~bit.
//              Falls 1..8 drive cmd[0..7], LSB first. Fall 9 drives parity.
//              Fall 10 releases data (stop bit, dat_oe=0), then -> ACK.
//   ACK        On fall 11, sample the synced data: 0 = ack, 1 = nak. Then -> WAIT_IDLE.
//   WAIT_IDLE  Wait until both synced lines are 1, then pulse done (ack) or error (nak),
//              then -> IDLE.
//  Watchdog: counts cycles in SHIFT, ACK and WAIT_IDLE and clears on every fall.
//   When it reaches TIMEOUT_CYCLES: release both lines, pulse error, -> IDLE.
//   A watchdog timeout in WAIT_IDLE also reports error, even after an ack.
//  done and error are never high in the same cycle, and never high outside a single-cycle pulse.
//  send arriving while busy is dropped, with no queueing.
//  A fall during IDLE, INHIBIT or START is ignored.
//  Width rules: the inhibit and watchdog counters are sized $clog2(param+1); bitcnt is 4 bits.
// STRUCTURE
//  ps2_defs package: FSM state encoding and the constants PS2_CMD_SET_LED=8'hED,
//   PS2_CMD_ENABLE=8'hF4, PS2_CMD_RESET=8'hFF, PS2_ACK=8'hFA.
//  Sub-module ps2_line_sync: synchronizer + falling-edge detect. The receiver reuses it.
//  Remainder: single FSM + shift register + two counters, all in ps2_host_tx.
// TESTING
//  Bench: device model drives clk_in at 12 kHz. Parameter overrides: INHIBIT_CYCLES=50,
//   TIMEOUT_CYCLES=2000.
//  1 send cmd=0xED -> clk_oe high for 50 cycles, then the start bit. Device samples
//    0,1,0,1,1,0,1,1,1, parity=1, stop=1. The model acks -> one done pulse, ready=1.
//  2 cmd=0xF4 -> data bits 0,0,1,0,1,1,1,1 and parity=0. Model naks (data high at fall 11)
//    -> one error pulse, no done.
//  3 After the start bit the model never clocks -> after 2000 cycles both oe=0, error
//    pulses, ready=1.
//  4 send pulsed again during the frame of 0xFF -> ignored. The wire carries exactly one
//    0xFF frame with parity=1.
//  5 resetn=0 during SHIFT at bit 4 -> next cycle clk_oe=0, dat_oe=0, ready=1, no pulse.
//    A following send of 0xF4 completes with done.
//  6 Glitch: clk_in toggles during INHIBIT -> no bit advance. The frame is still bit-exact.

Source files
------------

// File: rtl/ps2_defs_pkg.sv
// Shared PS/2 definitions: host-transmit FSM encoding and common keyboard command bytes.
package ps2_defs;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_START,
        ST_RELEASE,
        ST_SHIFT,
        ST_ACK,
        ST_WAIT_IDLE
    } ps2_state_t;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_ACK         = 8'hFA;

    // Fall count (before increment) at which the stop bit is released.
    localparam logic [3:0] STOP_FALL_IDX = 4'd9;

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronizes the raw PS/2 clock and data lines and flags falling edges of the clock line.
module ps2_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic clk_raw,
    input  logic dat_raw,
    output logic clk_sync,
    output logic dat_sync,
    output logic fall
);

    logic [SYNC_STAGES-1:0] clk_pipe;
    logic [SYNC_STAGES-1:0] dat_pipe;
    logic                   clk_prev;

    // Idle PS/2 lines float high, so the pipeline resets to 1 to avoid a phantom fall.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            clk_pipe <= '1;
            dat_pipe <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_pipe[0] <= clk_raw;
            dat_pipe[0] <= dat_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                clk_pipe[i] <= clk_pipe[i-1];
                dat_pipe[i] <= dat_pipe[i-1];
            end
            clk_prev <= clk_pipe[SYNC_STAGES-1];
        end
    end

    assign clk_sync = clk_pipe[SYNC_STAGES-1];
    assign dat_sync = dat_pipe[SYNC_STAGES-1];
    assign fall     = clk_prev & ~clk_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, sends start/8 data/odd parity/stop,
// checks the device ack and guards every device clock gap with a watchdog.
module ps2_host_tx
    import ps2_defs::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       send,
    input  logic [7:0] cmd,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

    ps2_state_t       state, state_n;
    logic [8:0]       shreg, shreg_n;
    logic [3:0]       bitcnt, bitcnt_n;
    logic [INH_W-1:0] inh_cnt, inh_cnt_n;
    logic [WD_W-1:0]  wd_cnt, wd_cnt_n;
    logic             dat_drv, dat_drv_n;
    logic             ack_ok, ack_ok_n;
    logic             done_n, error_n;
    logic             clk_sync, dat_sync, clk_fall;
    logic             watching;

    ps2_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .resetn   (resetn),
        .clk_raw  (ps2_clk_in),
        .dat_raw  (ps2_dat_in),
        .clk_sync (clk_sync),
        .dat_sync (dat_sync),
        .fall     (clk_fall)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values computed by the combinational block.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bitcnt  <= '0;
            inh_cnt <= '0;
            wd_cnt  <= '0;
            dat_drv <= 1'b0;
            ack_ok  <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            bitcnt  <= bitcnt_n;
            inh_cnt <= inh_cnt_n;
            wd_cnt  <= wd_cnt_n;
            dat_drv <= dat_drv_n;
            ack_ok  <= ack_ok_n;
            done    <= done_n;
            error   <= error_n;
        end
    end

    assign watching = (state == ST_SHIFT) || (state == ST_ACK) || (state == ST_WAIT_IDLE);

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // forgets an assignment would otherwise infer a latch.
        state_n   = state;
        shreg_n   = shreg;
        bitcnt_n  = bitcnt;
        inh_cnt_n = inh_cnt;
        wd_cnt_n  = wd_cnt;
        dat_drv_n = dat_drv;
        ack_ok_n  = ack_ok;
        done_n    = 1'b0;
        error_n   = 1'b0;

        if (watching) begin
            wd_cnt_n = clk_fall ? '0 : wd_cnt + 1'b1;
        end

        case (state)
            ST_IDLE: begin
                if (send) begin
                    shreg_n   = {~^cmd, cmd};
                    inh_cnt_n = '0;
                    state_n   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (inh_cnt == INH_LAST) state_n = ST_START;
                else                     inh_cnt_n = inh_cnt + 1'b1;
            end
            ST_START: begin
                state_n = ST_RELEASE;
            end
            ST_RELEASE: begin
                dat_drv_n = 1'b1;
                bitcnt_n  = '0;
                wd_cnt_n  = '0;
                state_n   = ST_SHIFT;
            end
            ST_SHIFT: begin
                // Each fall puts the next bit on the wire; the device samples it on the rise.
                if (clk_fall) begin
                    bitcnt_n = bitcnt + 4'd1;
                    if (bitcnt == STOP_FALL_IDX) begin
                        dat_drv_n = 1'b0;
                        state_n   = ST_ACK;
                    end else begin
                        dat_drv_n = ~shreg[0];
                        shreg_n   = {1'b0, shreg[8:1]};
                    end
                end
            end
            ST_ACK: begin
                if (clk_fall) begin
                    bitcnt_n = bitcnt + 4'd1;
                    ack_ok_n = ~dat_sync;
                    state_n  = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_sync && dat_sync) begin
                    done_n  = ack_ok;
                    error_n = ~ack_ok;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // The watchdog overrides everything, including an ack already seen.
        if (watching && (wd_cnt == WD_LIMIT)) begin
            state_n   = ST_IDLE;
            dat_drv_n = 1'b0;
            wd_cnt_n  = '0;
            done_n    = 1'b0;
            error_n   = 1'b1;
        end
    end

    assign ready      = (state == ST_IDLE);
    assign busy       = ~ready;
    assign ps2_clk_oe = (state == ST_INHIBIT) || (state == ST_START);
    assign ps2_dat_oe = (state == ST_START) || (state == ST_RELEASE) ||
                        ((state == ST_SHIFT) && dat_drv);

endmodule
